// File: rtl/decode_stage.sv
// decode_stage
//   Registered instruction-decode stage sitting between fetch and execute.
//   Decodes an RV32I/RV64I subset (addi, lui, auipc, jal, jalr, branches,
//   loads, stores, ebreak) and holds one decoded entry in a pipeline register
//   with valid/ready handshakes on both sides.
//
// Parameters
//   XLEN      datapath / immediate width, 32 or 64
//   PC_W      program counter width
//   INST_W    instruction width (32)
//   REG_ID_W  register index width
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          fetch-side handshake
//   in_inst, in_pc             instruction word and its PC
//   flush                      drop the held entry, refuse accept this cycle
//   out_valid/out_ready        execute-side handshake
//   out_pc, out_rd/rs1/rs2     captured PC and register fields
//   out_imm                    sign-extended immediate (XLEN)
//   out_need_imm, out_alu_add  ALU operand / operation controls
//   out_br, out_br_f3          conditional branch and its funct3
//   out_load, out_store        memory op flags
//   out_mem_size, out_load_uns access size (0=B..3=D), zero-extend load
//   out_wmask                  low-aligned byte write mask for stores
//   out_reg_wen                instruction writes rd
//   out_jal/jalr/auipc/lui/ebreak  special-op flags
//   out_not_ipl                unimplemented / illegal encoding
//   halted                     sticky, set when an ebreak is accepted
module decode_stage #(
  parameter int XLEN     = 64,
  parameter int PC_W     = 64,
  parameter int INST_W   = 32,
  parameter int REG_ID_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_W-1:0]   in_inst,
  input  logic [PC_W-1:0]     in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [REG_ID_W-1:0] out_rd,
  output logic [REG_ID_W-1:0] out_rs1,
  output logic [REG_ID_W-1:0] out_rs2,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_need_imm,
  output logic                out_alu_add,
  output logic                out_br,
  output logic [2:0]          out_br_f3,
  output logic                out_load,
  output logic                out_store,
  output logic [1:0]          out_mem_size,
  output logic                out_load_uns,
  output logic [XLEN/8-1:0]   out_wmask,
  output logic                out_reg_wen,
  output logic                out_jal,
  output logic                out_jalr,
  output logic                out_auipc,
  output logic                out_lui,
  output logic                out_ebreak,
  output logic                out_not_ipl,
  output logic                halted
);

  localparam int  NB   = XLEN / 8;
  localparam logic IS64 = (XLEN == 64);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [REG_ID_W-1:0] rd;
    logic [REG_ID_W-1:0] rs1;
    logic [REG_ID_W-1:0] rs2;
    logic [XLEN-1:0]     imm;
    logic                need_imm;
    logic                alu_add;
    logic                br;
    logic [2:0]          br_f3;
    logic                load;
    logic                store;
    logic [1:0]          mem_size;
    logic                load_uns;
    logic [NB-1:0]       wmask;
    logic                reg_wen;
    logic                jal;
    logic                jalr;
    logic                auipc;
    logic                lui;
    logic                ebreak;
    logic                not_ipl;
  } dec_t;

  // ---------------------------------------------------------------------
  // Instruction fields and immediates
  // ---------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] f3;
  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];

  // Every immediate is first formed as a signed 32-bit value, then widened
  // with a signed cast so the same code sign-extends correctly at XLEN=32/64.
  logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
  assign imm_i32 = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                    in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u32 = {in_inst[31:12], 12'b0};
  assign imm_j32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                    in_inst[20], in_inst[30:21], 1'b0};

  // ---------------------------------------------------------------------
  // Opcode classification (legal forms only)
  // ---------------------------------------------------------------------
  logic is_addi, is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_load, is_store, is_ebreak, is_nop, legal;

  always_comb begin
    is_addi   = 1'b0;
    is_lui    = 1'b0;
    is_auipc  = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_br     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_ebreak = 1'b0;
    is_nop    = 1'b0;
    unique case (opcode)
      OPC_OP_IMM: is_addi  = (f3 == 3'b000);
      OPC_LUI:    is_lui   = 1'b1;
      OPC_AUIPC:  is_auipc = 1'b1;
      OPC_JAL:    is_jal   = 1'b1;
      OPC_JALR:   is_jalr  = (f3 == 3'b000);
      OPC_BRANCH: is_br    = (f3 != 3'b010) && (f3 != 3'b011);
      OPC_LOAD: begin
        unique case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load = 1'b1;
          3'b011, 3'b110:                         is_load = IS64;
          default:                                is_load = 1'b0;
        endcase
      end
      OPC_STORE: begin
        unique case (f3)
          3'b000, 3'b001, 3'b010: is_store = 1'b1;
          3'b011:                 is_store = IS64;
          default:                is_store = 1'b0;
        endcase
      end
      OPC_SYSTEM: is_ebreak = (in_inst == EBREAK_WORD);
      default:    is_nop    = (in_inst == '0);
    endcase
  end

  assign legal = is_addi | is_lui | is_auipc | is_jal | is_jalr | is_br |
                 is_load | is_store | is_ebreak | is_nop;

  // ---------------------------------------------------------------------
  // Store byte mask: lane gi is enabled when it lies inside 2^size bytes.
  // ---------------------------------------------------------------------
  logic [3:0]    size_lanes;
  logic [NB-1:0] wmask_next;
  assign size_lanes = 4'd1 << f3[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_wmask
      localparam logic [3:0] LANE = gi;
      assign wmask_next[gi] = is_store & (size_lanes > LANE);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Decoded entry
  // ---------------------------------------------------------------------
  dec_t dec_next;

  always_comb begin
    dec_next     = '0;
    dec_next.pc  = in_pc;
    dec_next.rd  = REG_ID_W'(in_inst[11:7]);
    dec_next.rs1 = REG_ID_W'(in_inst[19:15]);
    dec_next.rs2 = REG_ID_W'(in_inst[24:20]);

    // Immediate selected by opcode alone, so illegal variants of a known
    // format still carry their immediate.
    unique case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: dec_next.imm = XLEN'(imm_i32);
      OPC_STORE:                      dec_next.imm = XLEN'(imm_s32);
      OPC_BRANCH:                     dec_next.imm = XLEN'(imm_b32);
      OPC_LUI, OPC_AUIPC:             dec_next.imm = XLEN'(imm_u32);
      OPC_JAL:                        dec_next.imm = XLEN'(imm_j32);
      default:                        dec_next.imm = '0;
    endcase

    dec_next.alu_add  = is_addi | is_auipc | is_lui | is_load | is_store | is_jalr;
    dec_next.need_imm = is_addi | is_auipc | is_lui | is_load | is_store | is_jalr;
    dec_next.reg_wen  = is_addi | is_lui | is_auipc | is_jal | is_jalr | is_load;
    dec_next.br       = is_br;
    dec_next.br_f3    = is_br ? f3 : 3'b000;
    dec_next.load     = is_load;
    dec_next.store    = is_store;
    dec_next.mem_size = (is_load | is_store) ? f3[1:0] : 2'b00;
    dec_next.load_uns = is_load & f3[2];
    dec_next.wmask    = wmask_next;
    dec_next.jal      = is_jal;
    dec_next.jalr     = is_jalr;
    dec_next.auipc    = is_auipc;
    dec_next.lui      = is_lui;
    dec_next.ebreak   = is_ebreak;
    dec_next.not_ipl  = ~legal;
  end

  // ---------------------------------------------------------------------
  // Pipeline register and handshake
  // ---------------------------------------------------------------------
  dec_t valid_dummy_unused;
  assign valid_dummy_unused = '0;

  dec_t dec_reg;
  logic valid_reg, halted_reg, accept;

  assign in_ready = ~halted_reg & ~flush & (~valid_reg | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
      dec_reg    <= '0;
    end else begin
      // flush wins; accept already excludes flush through in_ready
      if (flush)          valid_reg <= 1'b0;
      else if (accept)    valid_reg <= 1'b1;
      else if (out_ready) valid_reg <= 1'b0;

      if (accept) begin
        dec_reg <= dec_next;
        if (dec_next.ebreak) halted_reg <= 1'b1;
      end
    end
  end

  assign out_valid    = valid_reg;
  assign halted       = halted_reg;
  assign out_pc       = dec_reg.pc;
  assign out_rd       = dec_reg.rd;
  assign out_rs1      = dec_reg.rs1;
  assign out_rs2      = dec_reg.rs2;
  assign out_imm      = dec_reg.imm;
  assign out_need_imm = dec_reg.need_imm;
  assign out_alu_add  = dec_reg.alu_add;
  assign out_br       = dec_reg.br;
  assign out_br_f3    = dec_reg.br_f3;
  assign out_load     = dec_reg.load;
  assign out_store    = dec_reg.store;
  assign out_mem_size = dec_reg.mem_size;
  assign out_load_uns = dec_reg.load_uns;
  assign out_wmask    = dec_reg.wmask;
  assign out_reg_wen  = dec_reg.reg_wen;
  assign out_jal      = dec_reg.jal;
  assign out_jalr     = dec_reg.jalr;
  assign out_auipc    = dec_reg.auipc;
  assign out_lui      = dec_reg.lui;
  assign out_ebreak   = dec_reg.ebreak;
  assign out_not_ipl  = dec_reg.not_ipl;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_ready;

  // XLEN=64 instance
  logic        in_ready, out_valid, halted;
  logic [63:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_need_imm, out_alu_add, out_br, out_load, out_store, out_load_uns;
  logic [2:0]  out_br_f3;
  logic [1:0]  out_mem_size;
  logic [7:0]  out_wmask;
  logic        out_reg_wen, out_jal, out_jalr, out_auipc, out_lui, out_ebreak, out_not_ipl;

  // XLEN=32 instance, same stimulus
  logic        w_in_ready, w_out_valid, w_halted;
  logic [63:0] w_out_pc;
  logic [31:0] w_out_imm;
  logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
  logic        w_need_imm, w_alu_add, w_br, w_load, w_store, w_load_uns;
  logic [2:0]  w_br_f3;
  logic [1:0]  w_mem_size;
  logic [3:0]  w_wmask;
  logic        w_reg_wen, w_jal, w_jalr, w_auipc, w_lui, w_ebreak, w_not_ipl;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_need_imm(out_need_imm),
    .out_alu_add(out_alu_add), .out_br(out_br), .out_br_f3(out_br_f3),
    .out_load(out_load), .out_store(out_store), .out_mem_size(out_mem_size),
    .out_load_uns(out_load_uns), .out_wmask(out_wmask), .out_reg_wen(out_reg_wen),
    .out_jal(out_jal), .out_jalr(out_jalr), .out_auipc(out_auipc), .out_lui(out_lui),
    .out_ebreak(out_ebreak), .out_not_ipl(out_not_ipl), .halted(halted)
  );

  decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_pc(w_out_pc), .out_rd(w_out_rd), .out_rs1(w_out_rs1),
    .out_rs2(w_out_rs2), .out_imm(w_out_imm), .out_need_imm(w_need_imm),
    .out_alu_add(w_alu_add), .out_br(w_br), .out_br_f3(w_br_f3),
    .out_load(w_load), .out_store(w_store), .out_mem_size(w_mem_size),
    .out_load_uns(w_load_uns), .out_wmask(w_wmask), .out_reg_wen(w_reg_wen),
    .out_jal(w_jal), .out_jalr(w_jalr), .out_auipc(w_auipc), .out_lui(w_lui),
    .out_ebreak(w_ebreak), .out_not_ipl(w_not_ipl), .halted(w_halted)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with out_ready=1 for a single accept edge.
  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    in_valid  = 1'b1;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = 1'b1;
    flush     = 1'b0;
    tick();
    in_valid  = 1'b0;
    $display("txn inst=%08h pc=%h valid=%0d not_ipl=%0d", inst, pc, out_valid, out_not_ipl);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid",   {63'd0, out_valid}, 64'd0);
    chk("rst_halted",  {63'd0, halted}, 64'd0);
    chk("rst_imm",     out_imm, 64'd0);
    chk("rst_regwen",  {63'd0, out_reg_wen}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // addi x1,x0,5
    send(32'h0050_0093, 64'h1000);
    chk("addi_valid",  {63'd0, out_valid}, 64'd1);
    chk("addi_pc",     out_pc, 64'h1000);
    chk("addi_rd",     {59'd0, out_rd}, 64'd1);
    chk("addi_rs1",    {59'd0, out_rs1}, 64'd0);
    chk("addi_imm",    out_imm, 64'd5);
    chk("addi_ctl",    {61'd0, out_alu_add, out_need_imm, out_reg_wen}, 64'b111);
    chk("addi_ipl",    {63'd0, out_not_ipl}, 64'd0);

    // sd x2,8(x1)
    send(32'h0020_B423, 64'h1004);
    chk("sd_store",    {63'd0, out_store}, 64'd1);
    chk("sd_size",     {62'd0, out_mem_size}, 64'd3);
    chk("sd_wmask",    {56'd0, out_wmask}, 64'hFF);
    chk("sd_imm",      out_imm, 64'd8);
    chk("sd_regs",     {54'd0, out_rs1, out_rs2}, {54'd0, 5'd1, 5'd2});
    chk("sd_regwen",   {63'd0, out_reg_wen}, 64'd0);
    chk("sd32_ipl",    {63'd0, w_not_ipl}, 64'd1);
    chk("sd32_store",  {63'd0, w_store}, 64'd0);
    chk("sd32_wmask",  {60'd0, w_wmask}, 64'd0);

    // sb x2,0(x1)
    send(32'h0020_8023, 64'h1008);
    chk("sb_wmask",    {56'd0, out_wmask}, 64'h01);
    chk("sb32_wmask",  {60'd0, w_wmask}, 64'h1);

    // lw x3,4(x1)
    send(32'h0040_A183, 64'h100C);
    chk("lw_ctl",      {60'd0, out_load, out_store, out_load_uns, out_reg_wen}, 64'b1001);
    chk("lw_size",     {62'd0, out_mem_size}, 64'd2);
    chk("lw_rd",       {59'd0, out_rd}, 64'd3);
    chk("lw_imm",      out_imm, 64'd4);
    chk("lw_wmask",    {56'd0, out_wmask}, 64'd0);

    // lbu x3,0(x1)
    send(32'h0000_C183, 64'h1010);
    chk("lbu_uns",     {61'd0, out_load_uns, out_mem_size}, 64'b100);

    // beq x1,x2,-4
    send(32'hFE20_8EE3, 64'h1014);
    chk("beq_br",      {60'd0, out_br, out_br_f3}, 64'b1000);
    chk("beq_imm",     out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq32_imm",   {32'd0, w_out_imm}, 64'hFFFF_FFFC);
    chk("beq_regwen",  {63'd0, out_reg_wen}, 64'd0);

    // lui x1,0x12345 and lui x1,0x80000 (sign extension)
    send(32'h1234_50B7, 64'h1018);
    chk("lui_imm",     out_imm, 64'h1234_5000);
    chk("lui_ctl",     {61'd0, out_lui, out_reg_wen, out_alu_add}, 64'b111);
    send(32'h8000_00B7, 64'h101C);
    chk("luineg_imm",  out_imm, 64'hFFFF_FFFF_8000_0000);

    // jal x1,-4
    send(32'hFFDF_F0EF, 64'h1020);
    chk("jal_imm",     out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jal_ctl",     {61'd0, out_jal, out_reg_wen, out_need_imm}, 64'b110);

    // all-ones word: illegal
    send(32'hFFFF_FFFF, 64'h1024);
    chk("ill_ipl",     {63'd0, out_not_ipl}, 64'd1);
    chk("ill_en",      {57'd0, out_reg_wen, out_store, out_load, out_br,
                        out_jal, out_jalr, out_ebreak}, 64'd0);
    chk("ill_rd",      {59'd0, out_rd}, 64'd31);

    // nop (all-zero)
    send(32'h0000_0000, 64'h1028);
    chk("nop_ctl",     {58'd0, out_not_ipl, out_reg_wen, out_alu_add,
                        out_need_imm, out_load, out_store}, 64'd0);

    // Backpressure, flush during stall, then resume
    send(32'h0050_0093, 64'h2000);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0040_A183; in_pc = 64'h2004;
    #1;
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("stall_valid", {63'd0, out_valid}, 64'd1);
    chk("stall_imm",   out_imm, 64'd5);
    chk("stall_pc",    out_pc, 64'h2000);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0;
    #1;
    chk("resume_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("resume_valid", {63'd0, out_valid}, 64'd1);
    chk("resume_rd",   {59'd0, out_rd}, 64'd3);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain_valid", {63'd0, out_valid}, 64'd0);
    chk("drain_hold",  {59'd0, out_rd}, 64'd3);

    // ebreak held in a stall, then reset mid-stall
    send(32'h0010_0073, 64'h3000);
    chk("ebrk_flags",  {61'd0, out_valid, halted, out_ebreak}, 64'b111);
    chk("ebrk_ipl",    {62'd0, out_not_ipl, out_reg_wen}, 64'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0050_0093;
    #1;
    chk("halt_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    tick();
    chk("rst2_state",  {61'd0, out_valid, halted, out_ebreak}, 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst2_in_ready", {63'd0, in_ready}, 64'd1);

    // ebreak then flush: halted survives flush, drain still works
    send(32'h0010_0073, 64'h3004);
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0050_0093;
    tick();
    chk("halt_drain",  {62'd0, out_valid, halted}, 64'b01);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("halt_flush",  {62'd0, halted, in_ready}, 64'b10);
    tick();
    chk("halt_noacc",  {63'd0, out_valid}, 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst3_halted", {62'd0, halted, in_ready}, 64'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
